// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, ALU operation classes, FSM states
// and datapath mux select encodings.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_R     = 3'b000,
    ALU_B     = 3'b001,
    ALU_LS    = 3'b010,
    ALU_I     = 3'b011,
    ALU_AUIPC = 3'b100,
    ALU_LUI   = 3'b101,
    ALU_JAL   = 3'b110,
    ALU_JALR  = 3'b111
  } aluop_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the sequencing FSM (master) and the datapath (slave).
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic [2:0] ALUOp;
  logic       ir_we;
  logic       pc_we;
  logic       pc_src;
  logic       alu_src_a;
  logic       alu_src_b;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_src;
  logic       reg_we;
  logic [1:0] result_src;
  logic       retire;
  logic       trap;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output ALUOp, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, mem_req,
           mem_we, mem_addr_src, reg_we, result_src, retire, trap
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  ALUOp, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, mem_req,
           mem_we, mem_addr_src, reg_we, result_src, retire, trap
  );
endinterface

// File: rtl/multicycle_control_unit_opcode_class_decode.sv
// Maps the instruction-register opcode to its ALU operation class and a
// legality flag; anything outside the supported RV32I subset is illegal.
module opcode_class_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output aluop_e     cls,
  output logic       legal
);
  always_comb begin
    cls   = ALU_R;
    legal = 1'b1;
    unique case (opcode)
      OP_R:      cls = ALU_R;
      OP_BRANCH: cls = ALU_B;
      OP_LOAD,
      OP_STORE:  cls = ALU_LS;
      OP_I:      cls = ALU_I;
      OP_AUIPC:  cls = ALU_AUIPC;
      OP_LUI:    cls = ALU_LUI;
      OP_JAL:    cls = ALU_JAL;
      OP_JALR:   cls = ALU_JALR;
      default:   legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on
// illegal opcodes and a variable-latency memory handshake.
module multicycle_control_unit
  import riscv_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus
);
  state_e state, state_nxt;
  aluop_e cls;
  logic   legal;
  logic   is_store, taken;
  logic   unused_funct3;

  // opcode comes straight from the instruction register, so it is already
  // stable from DECODE onwards (loaded on ir_we).
  opcode_class_decode u_dec (
    .opcode (bus.opcode),
    .cls    (cls),
    .legal  (legal)
  );

  assign is_store      = (bus.opcode == OP_STORE);
  assign taken         = bus.zero ^ bus.funct3[0];
  assign unused_funct3 = ^bus.funct3[2:1];

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (cls == ALU_LS)     state_nxt = S_MEM;
        else if (cls == ALU_B) state_nxt = S_FETCH;
        else                   state_nxt = S_WB;
      end
      S_MEM:    if (bus.mem_ready) state_nxt = is_store ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    bus.ALUOp        = ALU_R;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_src       = PC_PLUS4;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_src = 1'b0;
    bus.reg_we       = 1'b0;
    bus.result_src   = RES_ALU;
    bus.retire       = 1'b0;
    bus.trap         = 1'b0;
    // reset masks every output, even mid-request
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
          end
        end
        S_EXEC: begin
          bus.ALUOp     = cls;
          bus.alu_src_b = !(cls == ALU_R || cls == ALU_B);
          bus.alu_src_a = (cls == ALU_AUIPC || cls == ALU_JAL);
          if (cls == ALU_B) begin
            bus.pc_we  = taken;
            bus.pc_src = taken ? PC_ALU : PC_PLUS4;
            bus.retire = 1'b1;
          end else if (cls == ALU_JAL || cls == ALU_JALR) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = PC_ALU;
          end
        end
        S_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_src = 1'b1;
          bus.mem_we       = is_store;
          bus.retire       = bus.mem_ready & is_store;
        end
        S_WB: begin
          bus.reg_we = 1'b1;
          bus.retire = 1'b1;
          if (bus.opcode == OP_LOAD)                          bus.result_src = RES_MEM;
          else if (cls == ALU_JAL || cls == ALU_JALR)         bus.result_src = RES_PC4;
        end
        S_TRAP:  bus.trap = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Per-cycle trace check of the control unit against an instruction-level
// model that expands each instruction into its expected output sequence.
module tb_multicycle_control_unit;
  typedef struct packed {
    logic [2:0] aluop;
    logic ir_we, pc_we, pc_src, a, b, mreq, mwe, maddr, reg_we;
    logic [1:0] res;
    logic retire, trap;
  } ctl_t;

  typedef struct {
    logic rdy;
    logic z;
    ctl_t exp;
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  cyc_t q[$];

  multicycle_control_unit_if bus();
  multicycle_control_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    return {bus.ALUOp, bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_src_a,
            bus.alu_src_b, bus.mem_req, bus.mem_we, bus.mem_addr_src,
            bus.reg_we, bus.result_src, bus.retire, bus.trap};
  endfunction

  task automatic push(input ctl_t c, input logic rdy, input logic z);
    cyc_t e;
    e.rdy = rdy; e.z = z; e.exp = c;
    q.push_back(e);
  endtask

  // Expand one instruction into expected per-cycle outputs. full=0 stops the
  // trace inside MEM (used for abandoning a stalled store via reset).
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input int fw, input int mw, input bit full);
    ctl_t c;
    logic [2:0] cls;
    bit legal, ld, st, br, jmp, taken;
    legal = 1;
    case (op)
      7'b0110011: cls = 3'b000;
      7'b1100011: cls = 3'b001;
      7'b0000011, 7'b0100011: cls = 3'b010;
      7'b0010011: cls = 3'b011;
      7'b0010111: cls = 3'b100;
      7'b0110111: cls = 3'b101;
      7'b1101111: cls = 3'b110;
      7'b1100111: cls = 3'b111;
      default: begin cls = 3'b000; legal = 0; end
    endcase
    ld  = (op == 7'b0000011);
    st  = (op == 7'b0100011);
    br  = (op == 7'b1100011);
    jmp = (op == 7'b1101111) || (op == 7'b1100111);
    for (int i = 0; i < fw; i++) begin
      c = '0; c.mreq = 1; push(c, 1'b0, 1'($urandom));
    end
    c = '0; c.mreq = 1; c.ir_we = 1; c.pc_we = 1;
    push(c, 1'b1, 1'($urandom));
    c = '0; push(c, 1'($urandom), 1'($urandom));
    if (!legal) return;
    c = '0;
    c.aluop = cls;
    c.b = !(op == 7'b0110011 || br);
    c.a = (op == 7'b0010111) || (op == 7'b1101111);
    if (br) begin
      taken = z ^ f3[0];
      c.pc_we = taken; c.pc_src = taken; c.retire = 1;
      push(c, 1'($urandom), z);
      return;
    end
    if (jmp) begin c.pc_we = 1; c.pc_src = 1; end
    push(c, 1'($urandom), z);
    if (ld || st) begin
      c = '0; c.mreq = 1; c.maddr = 1; c.mwe = st;
      for (int i = 0; i < mw; i++) push(c, 1'b0, 1'($urandom));
      if (!full) return;
      c.retire = st;
      push(c, 1'b1, 1'($urandom));
      if (st) return;
    end
    c = '0; c.reg_we = 1; c.retire = 1;
    c.res = ld ? 2'b01 : (jmp ? 2'b10 : 2'b00);
    push(c, 1'($urandom), 1'($urandom));
  endtask

  task automatic check(input string tag, input ctl_t exp);
    ctl_t o;
    o = observed();
    nchk++;
    assert (o === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, o, exp);
    end
  endtask

  // Each cycle: drive inputs just after negedge, check, advance to next negedge.
  task automatic run_q(input string tag);
    cyc_t e;
    int n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      bus.mem_ready = e.rdy;
      bus.zero = e.z;
      #1;
      check($sformatf("%s_c%0d", tag, n), e.exp);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check(tag, '0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic z, input int fw, input int mw);
    bus.opcode = op;
    bus.funct3 = f3;
    build(op, f3, z, fw, mw, 1'b1);
    run_q(tag);
  endtask

  logic [6:0] legal_ops [9];

  initial begin
    ctl_t c;
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    bus.opcode = 7'b0110011; bus.funct3 = '0; bus.zero = 0; bus.mem_ready = 1;
    @(negedge clk); @(negedge clk);
    #1 check("reset_hold", '0);
    @(negedge clk);
    reset = 1'b0;

    instr("add",     7'b0110011, 3'b000, 1'b0, 0, 0);
    instr("lw_wait", 7'b0000011, 3'b010, 1'b0, 0, 2);
    instr("bne_nz",  7'b1100011, 3'b001, 1'b0, 0, 0);
    instr("bne_z",   7'b1100011, 3'b001, 1'b1, 0, 0);
    instr("beq_z",   7'b1100011, 3'b000, 1'b1, 1, 0);
    instr("jalr",    7'b1100111, 3'b000, 1'b0, 0, 0);
    instr("jal",     7'b1101111, 3'b000, 1'b0, 2, 0);
    instr("sw",      7'b0100011, 3'b010, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++)
      instr($sformatf("rnd%0d", i), legal_ops[$urandom_range(0, 8)],
            3'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));

    // illegal opcode: trap is sticky until reset
    bus.opcode = 7'b1111111;
    build(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b1);
    c = '0; c.trap = 1;
    for (int i = 0; i < 20; i++) push(c, 1'($urandom), 1'($urandom));
    run_q("trap");
    reset_pulse("trap_reset");
    instr("add_after_trap", 7'b0110011, 3'b000, 1'b0, 0, 0);

    // stalled store abandoned by reset: no retire, fresh FETCH next
    bus.opcode = 7'b0100011;
    build(7'b0100011, 3'b010, 1'b0, 0, 2, 1'b0);
    run_q("sw_stall");
    reset_pulse("sw_reset");
    instr("after_sw_reset", 7'b0010011, 3'b000, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Main sequencing FSM for the multi-cycle RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back. It produces the 3-bit ALU operation class consumed by the ALU control decoder, plus every register, PC, memory and mux enable in the datapath. It also handles the variable-latency memory handshake and traps on unsupported opcodes.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  instruction[6:0] from instruction register
- funct3  in  3  instruction[14:12]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- ALUOp  out  3  class: 000 R, 001 B, 010 load/store, 011 I-ALU, 100 AUIPC, 101 LUI, 110 JAL, 111 JALR
- ir_we  out  1  load instruction register and old_pc/pc_plus4 latches
- pc_we  out  1  write PC
- pc_src  out  1  0 = pc_plus4, 1 = ALU result
- alu_src_a  out  1  0 = rs1, 1 = old_pc
- alu_src_b  out  1  0 = rs2, 1 = immediate
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier for mem_req
- mem_addr_src  out  1  0 = PC (fetch), 1 = ALU result register
- reg_we  out  1  register file write
- result_src  out  2  00 ALU result, 01 memory data, 10 pc_plus4
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky illegal-opcode flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are a combinational decode of state, latched opcode and inputs. Any output not listed for a state is 0.
- FETCH: mem_req=1, mem_addr_src=0. While mem_ready=0, stay. When mem_ready=1: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE: register read only. A legal opcode goes to EXEC. Any opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} goes to TRAP.
- EXEC: ALUOp is set from the opcode class.
  - alu_src_b=1 for all opcodes except R and B.
  - alu_src_a=1 for AUIPC and JAL.
  - R, I-ALU, LUI, AUIPC: go to WB.
  - Load and store: go to MEM.
  - BRANCH: taken = zero XOR funct3[0] (BEQ/BNE). If taken, pc_we=1 and pc_src=1. Then retire=1 and go to FETCH.
  - JAL and JALR: pc_we=1, pc_src=1, then go to WB.
- MEM: mem_req=1, mem_addr_src=1, and mem_we=1 for stores. Stay while mem_ready=0. On mem_ready=1, a store asserts retire and goes to FETCH; a load goes to WB.
- WB: reg_we=1, retire=1, then go to FETCH. result_src is 01 for loads, 10 for JAL/JALR, 00 otherwise.
- TRAP: trap=1 and all other outputs 0. The FSM stays in TRAP until reset.
- mem_req, once raised, holds stable (together with mem_we and mem_addr_src) until the cycle in which mem_ready=1.

## Timing
- Reset: while reset=1, every output is forced to 0. The state becomes FETCH on the edge. The first cycle after reset drops shows mem_req=1 and mem_addr_src=0.
- Reset mid-operation abandons the current instruction. The block does not wait for an outstanding mem_ready. No retire is emitted.
- Cycles per instruction with zero-wait memory (mem_ready=1 in the first request cycle):
  - branch: 3
  - R, I-ALU, LUI, AUIPC, JAL, JALR, store: 4
  - load: 5
- Each cycle of mem_ready=0 adds one cycle in FETCH or MEM.
- mem_ready is ignored outside FETCH and MEM.
- retire is asserted in the final cycle of an instruction. The next cycle is always FETCH.

## Structure
- Shared package riscv_pkg holds:
  - opcode localparams
  - ALUOp class constants (values above)
  - state enum
  - result_src and pc_src constants
- Sub-module opcode_class_decode: combinational opcode to {class, legal}. It is instantiated once and its outputs are registered with ir_we timing through the opcode input.
- FSM next-state logic and output decode live in multicycle_control_unit.

## Test plan
- ADD (opcode 0110011), mem_ready always 1 -> states FETCH, DECODE, EXEC, WB; ALUOp=000 in EXEC; reg_we=1 and retire=1 in cycle 4 only.
- LW with mem_ready low for 2 cycles in MEM -> mem_req held 3 cycles with mem_we=0 and mem_addr_src=1; WB follows with result_src=01; total 7 cycles.
- BNE (funct3=001): zero=0 -> pc_we=1 and pc_src=1 in EXEC; zero=1 -> pc_we=0; retire in cycle 3 in both cases.
- JALR -> ALUOp=111, pc_we=1 and pc_src=1 in EXEC; WB result_src=10.
- opcode 1111111 -> TRAP after DECODE; trap=1 and mem_req=0 for 20 cycles; reset returns to FETCH.
- reset asserted during MEM of a SW with mem_ready=0 -> all outputs 0 in the reset cycle; FETCH with mem_req=1 next; no retire.
